// File: rtl/vga_stream_out_if.sv
// Pixel stream handshake between the pixel processing unit and the VGA output stage.
// The producer drives a {r,g,b} word, a start-of-frame flag and valid; the stage answers with ready.
interface vga_stream_out_if #(
    parameter int CW = 2
);
    logic [3*CW-1:0] in_data;
    logic            in_sof;
    logic            in_valid;
    logic            in_ready;

    modport master (output in_data, output in_sof, output in_valid, input in_ready);
    modport slave  (input in_data, input in_sof, input in_valid, output in_ready);
endinterface

// File: rtl/vga_stream_out.sv
// Pixel-stream-to-VGA output stage: configurable raster timing, elastic {sof,pixel} FIFO,
// start-of-frame locking, and blank-and-count handling of misaligned or missing pixels.
module vga_stream_out #(
    parameter int CW         = 2,
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit SYNC_POL   = 1'b0,
    parameter int FIFO_DEPTH = 16,
    parameter int ECW        = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  resync,
    vga_stream_out_if.slave       stream,
    output logic [CW-1:0]         vga_r,
    output logic [CW-1:0]         vga_g,
    output logic [CW-1:0]         vga_b,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  de,
    output logic [11:0]           sx,
    output logic [11:0]           sy,
    output logic                  frame_start,
    output logic                  locked,
    output logic [ECW-1:0]        err_cnt
);
    localparam int DW = 3 * CW;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [11:0] H_ACT_L   = 12'(H_ACTIVE);
    localparam logic [11:0] H_SS_L    = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] H_SE_L    = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] H_LAST_L  = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [11:0] V_ACT_L   = 12'(V_ACTIVE);
    localparam logic [11:0] V_SS_L    = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] V_SE_L    = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [11:0] V_LAST_L  = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [AW:0] DEPTH_L   = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [0:0] {SEEK = 1'b0, RUN = 1'b1} state_t;

    // Saturating increment for the fault counter.
    function automatic logic [ECW-1:0] sat_inc(input logic [ECW-1:0] v);
        if (v == {ECW{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + ECW'(1);
        end
    endfunction

    state_t          state_r, state_nx_s;
    logic [11:0]     hc_r, vc_r, hc_s, vc_s, hc_nx_s, vc_nx_s;
    logic [DW:0]     mem_r [FIFO_DEPTH];
    logic [AW:0]     wr_ptr_r, rd_ptr_r, count_s;
    logic            full_s, empty_s, push_s, pop_s, fault_s;
    logic            active_s, origin_s, hs_s, vs_s;
    logic [DW:0]     head_s;
    logic [DW-1:0]   pix_s, pix_r;
    logic            de_r, hsync_r, vsync_r, frame_start_r, locked_r;
    logic [11:0]     sx_r, sy_r;
    logic [ECW-1:0]  err_r;

    assign count_s         = wr_ptr_r - rd_ptr_r;
    assign full_s          = (count_s == DEPTH_L);
    assign empty_s         = (count_s == {(AW + 1){1'b0}});
    assign head_s          = mem_r[rd_ptr_r[AW-1:0]];
    assign stream.in_ready = ~full_s;
    // A push in the resync cycle is dropped because the FIFO is being flushed.
    assign push_s          = stream.in_valid & ~full_s & ~resync;

    // Current raster position; resync makes this very cycle pixel (0,0) so the next outputs show it.
    always_comb begin
        hc_s    = resync ? 12'd0 : hc_r;
        vc_s    = resync ? 12'd0 : vc_r;
        hc_nx_s = hc_s + 12'd1;
        vc_nx_s = vc_s;
        if (hc_s == H_LAST_L) begin
            hc_nx_s = 12'd0;
            if (vc_s == V_LAST_L) begin
                vc_nx_s = 12'd0;
            end else begin
                vc_nx_s = vc_s + 12'd1;
            end
        end else begin
            hc_nx_s = hc_s + 12'd1;
        end
        active_s = (hc_s < H_ACT_L) && (vc_s < V_ACT_L);
        origin_s = (hc_s == 12'd0) && (vc_s == 12'd0);
        hs_s     = (hc_s >= H_SS_L) && (hc_s < H_SE_L);
        vs_s     = (vc_s >= V_SS_L) && (vc_s < V_SE_L);
    end

    // Lock FSM next state plus pop/display/fault decisions from the current FIFO head.
    always_comb begin
        state_nx_s = state_r;
        pop_s      = 1'b0;
        fault_s    = 1'b0;
        pix_s      = {DW{1'b0}};
        if (resync) begin
            state_nx_s = SEEK;
        end else begin
            case (state_r)
                SEEK: begin
                    if (empty_s) begin
                        pop_s = 1'b0;
                    end else if (!head_s[DW]) begin
                        pop_s = 1'b1;                       // discard words until a frame start
                    end else if (origin_s) begin
                        pop_s      = 1'b1;
                        pix_s      = head_s[DW-1:0];
                        state_nx_s = RUN;
                    end else begin
                        pop_s = 1'b0;                       // hold the sof word until (0,0)
                    end
                end
                RUN: begin
                    if (!active_s) begin
                        pop_s = 1'b0;
                    end else if (empty_s) begin
                        fault_s    = 1'b1;                  // underflow
                        state_nx_s = SEEK;
                    end else if (head_s[DW] && !origin_s) begin
                        fault_s    = 1'b1;                  // early sof: keep it for the next frame
                        state_nx_s = SEEK;
                    end else if (!head_s[DW] && origin_s) begin
                        fault_s    = 1'b1;                  // late sof: drop the stray word
                        pop_s      = 1'b1;
                        state_nx_s = SEEK;
                    end else begin
                        pop_s = 1'b1;
                        pix_s = head_s[DW-1:0];
                    end
                end
                default: begin
                    state_nx_s = SEEK;
                end
            endcase
        end
    end

    // Lock state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= SEEK;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Raster counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hc_r <= 12'd0;
            vc_r <= 12'd0;
        end else begin
            hc_r <= hc_nx_s;
            vc_r <= vc_nx_s;
        end
    end

    // FIFO pointers; resync flushes by collapsing both pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {(AW + 1){1'b0}};
            rd_ptr_r <= {(AW + 1){1'b0}};
        end else if (resync) begin
            wr_ptr_r <= {(AW + 1){1'b0}};
            rd_ptr_r <= {(AW + 1){1'b0}};
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + (AW + 1)'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + (AW + 1)'(1);
        end
    end

    // FIFO storage; contents are meaningless outside the pointer window so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_s) mem_r[wr_ptr_r[AW-1:0]] <= {stream.in_sof, stream.in_data};
    end

    // Video output registers, one cycle behind the raster position that produced them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_r         <= {DW{1'b0}};
            de_r          <= 1'b0;
            hsync_r       <= ~SYNC_POL;
            vsync_r       <= ~SYNC_POL;
            sx_r          <= 12'd0;
            sy_r          <= 12'd0;
            frame_start_r <= 1'b0;
            locked_r      <= 1'b0;
            err_r         <= {ECW{1'b0}};
        end else begin
            pix_r         <= pix_s;
            de_r          <= active_s;
            hsync_r       <= hs_s ? SYNC_POL : ~SYNC_POL;
            vsync_r       <= vs_s ? SYNC_POL : ~SYNC_POL;
            sx_r          <= hc_s;
            sy_r          <= vc_s;
            frame_start_r <= origin_s;
            locked_r      <= (state_nx_s == RUN);
            if (fault_s) err_r <= sat_inc(err_r);
        end
    end

    assign vga_r       = pix_r[3*CW-1:2*CW];
    assign vga_g       = pix_r[2*CW-1:CW];
    assign vga_b       = pix_r[CW-1:0];
    assign de          = de_r;
    assign hsync       = hsync_r;
    assign vsync       = vsync_r;
    assign sx          = sx_r;
    assign sy          = sy_r;
    assign frame_start = frame_start_r;
    assign locked      = locked_r;
    assign err_cnt     = err_r;
endmodule

// File: tb/tb_vga_stream_out.sv
// Directed bench: default 640x480 timing on one instance, a tiny 8x4 raster with a
// small fault counter on another for locking, fault, saturation and resync behaviour.
module tb_vga_stream_out;
    logic clk = 1'b0;
    logic rst_n;
    logic resync;
    logic big_resync;
    always #5 clk = ~clk;

    vga_stream_out_if #(.CW(2)) bus ();
    vga_stream_out_if #(.CW(2)) big_bus ();

    logic [1:0]  s_r, s_g, s_b, b_r, b_g, b_b;
    logic        s_hs, s_vs, s_de, s_fs, s_lk, b_hs, b_vs, b_de, b_fs, b_lk;
    logic [11:0] s_sx, s_sy, b_sx, b_sy;
    logic [2:0]  s_err;
    logic [15:0] b_err;
    logic [5:0]  s_rgb, b_rgb;
    assign s_rgb = {s_r, s_g, s_b};
    assign b_rgb = {b_r, b_g, b_b};

    vga_stream_out #(
        .CW(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1'b1), .FIFO_DEPTH(16), .ECW(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .resync(resync), .stream(bus),
        .vga_r(s_r), .vga_g(s_g), .vga_b(s_b), .hsync(s_hs), .vsync(s_vs), .de(s_de),
        .sx(s_sx), .sy(s_sy), .frame_start(s_fs), .locked(s_lk), .err_cnt(s_err)
    );

    vga_stream_out dut_big (
        .clk(clk), .rst_n(rst_n), .resync(big_resync), .stream(big_bus),
        .vga_r(b_r), .vga_g(b_g), .vga_b(b_b), .hsync(b_hs), .vsync(b_vs), .de(b_de),
        .sx(b_sx), .sy(b_sy), .frame_start(b_fs), .locked(b_lk), .err_cnt(b_err)
    );

    int n_pass = 0;
    int n_total = 0;
    int accepted = 0;
    logic [6:0] txq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Present the head of the software queue to the small instance.
    task automatic drive();
        if (txq.size() > 0) begin
            bus.in_valid = 1'b1;
            bus.in_sof   = txq[0][6];
            bus.in_data  = txq[0][5:0];
        end else begin
            bus.in_valid = 1'b0;
            bus.in_sof   = 1'b0;
            bus.in_data  = 6'd0;
        end
    endtask

    // One clock: note acceptance before the edge, sample outputs 1 time unit after it.
    task automatic tick();
        logic       acc;
        logic [6:0] w;
        acc = bus.in_valid && bus.in_ready && !resync && rst_n;
        @(posedge clk);
        if (acc) begin
            w = txq.pop_front();
            accepted++;
        end
        #1;
        drive();
    endtask

    task automatic wait_fs(input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (s_fs !== 1'b1 && n < 200);
        chk(tag, s_fs, 1);
    endtask

    task automatic wait_pos(input logic [11:0] x, input logic [11:0] y, input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while ((s_sx !== x || s_sy !== y) && n < 200);
        chk(tag, {s_sx, s_sy}, {x, y});
    endtask

    initial begin
        int k;
        int cnt;
        rst_n = 1'b0;
        resync = 1'b0;
        big_resync = 1'b0;
        big_bus.in_valid = 1'b0;
        big_bus.in_sof = 1'b0;
        big_bus.in_data = 6'd0;
        drive();
        repeat (3) tick();

        // Reset values on both instances
        chk("rst_rgb", s_rgb, 0);      chk("rst_de", s_de, 0);
        chk("rst_hs", s_hs, 0);        chk("rst_vs", s_vs, 0);
        chk("rst_sx", s_sx, 0);        chk("rst_sy", s_sy, 0);
        chk("rst_fs", s_fs, 0);        chk("rst_lk", s_lk, 0);
        chk("rst_err", s_err, 0);
        chk("rst_big_hs", b_hs, 1);    chk("rst_big_vs", b_vs, 1);
        chk("rst_big_rgb", b_rgb, 0);  chk("rst_big_err", b_err, 0);
        chk("rst_big_fs", b_fs, 0);    chk("rst_big_lk", b_lk, 0);

        // Default timing, line 0
        rst_n = 1'b1;
        tick();
        chk("ready_after_rst", bus.in_ready, 1);
        chk("big_ready_after_rst", big_bus.in_ready, 1);
        chk("big_first_sx", b_sx, 0);
        for (int i = 0; i < 800; i++) begin
            tick();
            if (b_sy == 12'd0 && b_sx == 12'd639) chk("big_de_639", b_de, 1);
            if (b_sy == 12'd0 && b_sx == 12'd640) chk("big_de_640", b_de, 0);
            if (b_sy == 12'd0 && b_sx == 12'd655) chk("big_hs_655", b_hs, 1);
            if (b_sy == 12'd0 && b_sx == 12'd656) chk("big_hs_656", b_hs, 0);
            if (b_sy == 12'd0 && b_sx == 12'd656) chk("big_vs_line0", b_vs, 1);
            if (b_sy == 12'd0 && b_sx == 12'd751) chk("big_hs_751", b_hs, 0);
            if (b_sy == 12'd0 && b_sx == 12'd752) chk("big_hs_752", b_hs, 1);
        end
        chk("big_wrap_sy", b_sy, 1);

        // Small raster: junk, then a counting frame, then a 20-word frame
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        accepted = 0;
        for (int i = 0; i < 5; i++) txq.push_back({1'b0, 6'(50 + i)});
        for (int i = 0; i < 32; i++) txq.push_back({i == 0, 6'(i)});
        for (int i = 0; i < 20; i++) txq.push_back({i == 0, 6'(32 + i)});
        drive();
        repeat (40) tick();
        chk("full_ready_low", bus.in_ready, 0);
        chk("full_accepted", accepted, 21);
        chk("prelock_lk", s_lk, 0);

        wait_fs("f1_start");
        chk("f1_lock", s_lk, 1);
        chk("f1_pix0", s_rgb, 0);
        chk("f1_de0", s_de, 1);
        k = 1;
        for (int i = 1; i < 98; i++) begin
            tick();
            if (s_de) begin
                chk("f1_pix", s_rgb, k);
                k++;
            end
            if (s_sy == 12'd0 && s_sx == 12'd9)  chk("hs_9", s_hs, 0);
            if (s_sy == 12'd0 && s_sx == 12'd10) chk("hs_10", s_hs, 1);
            if (s_sy == 12'd0 && s_sx == 12'd11) chk("hs_11", s_hs, 1);
            if (s_sy == 12'd0 && s_sx == 12'd12) chk("hs_12", s_hs, 0);
            if (s_sx == 12'd0 && s_sy == 12'd4)  chk("vs_4", s_vs, 0);
            if (s_sx == 12'd0 && s_sy == 12'd5)  chk("vs_5", s_vs, 1);
            if (s_sx == 12'd0 && s_sy == 12'd6)  chk("vs_6", s_vs, 0);
        end
        chk("f1_count", k, 32);
        chk("f1_err", s_err, 0);
        chk("f1_still_lk", s_lk, 1);
        tick();
        chk("frame_period", s_fs, 1);
        chk("f2_pix0", s_rgb, 32);

        // Underflow at pixel 20 of frame 2
        wait_pos(12'd3, 12'd2, "u_pos19");
        chk("u_pix19", s_rgb, 51);
        tick();
        chk("u_sx", s_sx, 4);
        chk("u_pix20", s_rgb, 0);
        chk("u_de", s_de, 1);
        chk("u_err", s_err, 1);
        chk("u_lk", s_lk, 0);

        // Relock, then early sof at pixel 5
        txq.push_back({1'b1, 6'd10});
        for (int i = 1; i < 5; i++) txq.push_back({1'b0, 6'(10 + i)});
        for (int i = 0; i < 32; i++) txq.push_back({i == 0, 6'(32 + i)});
        drive();
        wait_fs("f3_start");
        chk("f3_lock", s_lk, 1);
        chk("f3_pix0", s_rgb, 10);
        chk("f3_err", s_err, 1);
        wait_pos(12'd4, 12'd0, "e_pos4");
        chk("e_pix4", s_rgb, 14);
        tick();
        chk("e_pix5", s_rgb, 0);
        chk("e_de", s_de, 1);
        chk("e_err", s_err, 2);
        chk("e_lk", s_lk, 0);
        wait_fs("f4_start");
        chk("f4_lock", s_lk, 1);
        chk("f4_pix0", s_rgb, 32);
        wait_pos(12'd7, 12'd3, "f4_last");
        chk("f4_pix31", s_rgb, 63);
        chk("f4_err", s_err, 2);
        wait_fs("f5_start");
        chk("f5_pix0", s_rgb, 0);
        chk("f5_err", s_err, 3);
        chk("f5_lk", s_lk, 0);

        // One error per frame until the 3-bit counter saturates
        for (int j = 1; j <= 5; j++) txq.push_back({1'b1, 6'(j)});
        drive();
        for (int j = 1; j <= 5; j++) begin
            wait_fs("sat_start");
            chk("sat_lock", s_lk, 1);
            chk("sat_pix", s_rgb, j);
            tick();
            chk("sat_err", s_err, (3 + j > 7) ? 7 : 3 + j);
            chk("sat_lk", s_lk, 0);
        end

        // Fill the FIFO, then resync
        accepted = 0;
        txq.push_back({1'b1, 6'd7});
        for (int i = 0; i < 19; i++) txq.push_back({1'b0, 6'(8 + i)});
        drive();
        repeat (30) tick();
        chk("rs_full", bus.in_ready, 0);
        chk("rs_accepted", accepted, 16);
        resync = 1'b1;
        tick();
        resync = 1'b0;
        txq.delete();
        drive();
        chk("rs_sx", s_sx, 0);
        chk("rs_sy", s_sy, 0);
        chk("rs_fs", s_fs, 1);
        chk("rs_lk", s_lk, 0);
        chk("rs_rgb", s_rgb, 0);
        chk("rs_ready", bus.in_ready, 1);
        tick();
        chk("rs_sx1", s_sx, 1);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (s_fs !== 1'b1 && cnt < 200);
        chk("rs_period", cnt, 97);
        chk("rs_nolock", s_lk, 0);
        chk("rs_pix0", s_rgb, 0);
        chk("rs_err_kept", s_err, 7);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/vga_stream_out.md
# vga_stream_out

Parametrised successor to the fixed 640x480 VGA driver: a pixel-stream-to-VGA output stage with a configurable video timing generator, configurable per-channel colour width and sync polarity, and an elastic pixel FIFO with start-of-frame alignment. It sits between the pixel processing unit's output stream and the board VGA pins. Unlike the previous driver, it accepts a valid/ready stream instead of sampling a free-running bus. It locks each frame to an in-band start-of-frame flag and blanks and counts faults instead of displaying misaligned pixels.

## Interface
- CW, 2, colour bits per channel
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, active lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- SYNC_POL, 0, sync active level (0 = negative, 1 = positive)
- FIFO_DEPTH, 16, pixel FIFO entries (power of 2, >= 2)
- ECW, 16, fault counter width
- clk  in  1  pixel clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- resync  in  1  synchronous restart: counters to 0, FIFO flushed, state SEEK
- in_data  in  3*CW  pixel {r,g,b}, r in MSBs
- in_sof  in  1  in_data is pixel (0,0) of a frame
- in_valid  in  1  input word valid
- in_ready  out  1  FIFO can accept
- vga_r, vga_g, vga_b  out  CW each  colour, 0 outside active area
- hsync, vsync  out  1  sync, polarity per SYNC_POL
- de  out  1  active-area flag
- sx, sy  out  12 each  position of the pixel currently on the outputs
- frame_start  out  1  one-cycle pulse aligned with pixel (0,0) on the outputs
- locked  out  1  state is RUN
- err_cnt  out  ECW  saturating fault count

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP, V_TOTAL likewise. Internal hc counts 0..H_TOTAL-1, wraps, and increments vc at wrap. vc wraps at V_TOTAL-1.
- Active when hc < H_ACTIVE and vc < V_ACTIVE. Hsync asserted for H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC. Vsync uses the same rule on vc.
- The FIFO stores {sof, pixel}. A push happens when in_valid && in_ready. in_ready = !full, so there is no push when full, even if a pop occurs in the same cycle. A pop and a push in the same cycle are allowed when not full.
- State SEEK (reset state):
  - A non-empty head with sof=0 is popped and discarded, one per cycle, at any position.
  - A head with sof=1 is held until hc=0, vc=0. It is then popped, displayed, and the state moves to RUN.
- State RUN:
  - Each active cycle pops one head and displays it.
  - FIFO empty on an active cycle (underflow): display 0, err_cnt+1, state SEEK.
  - Head sof=1 on an active cycle other than (0,0) (early sof): display 0, no pop, err_cnt+1, state SEEK.
  - Head sof=0 at (0,0) (late sof): display 0, pop and discard, err_cnt+1, state SEEK.
- err_cnt saturates at all-ones.
- resync takes priority over all other events. err_cnt is kept across resync; only rst_n clears it.

## Timing
- Reset values:
  - Outputs: colours 0, de 0, hsync and vsync at the inactive level (~SYNC_POL), sx 0, sy 0, frame_start 0, locked 0, err_cnt 0.
  - Internal: FIFO empty, state SEEK.
  - in_ready is 1 from the first cycle after reset release.
- All video outputs are registered with a latency of 1 cycle from the (hc,vc) that produced them. sx and sy carry that same (hc,vc).
- Pop and display decisions use the head state in the same cycle. A word pushed in cycle t is first visible at the head in cycle t+1.
- locked rises in the cycle frame_start is high for the first locked frame. It falls in the cycle the faulty blank pixel appears on the outputs.
- frame_start pulses every frame, whether or not the block is locked.
- When resync is high in cycle t: the outputs in cycle t+1 show position (0,0); the FIFO is empty in cycle t+1; a push in cycle t is dropped.
- Steady state requires the input to sustain 1 pixel per active cycle. Blanking cycles absorb refill.

## Test plan
- Reset with defaults: hold rst_n=0, release -> all outputs at their reset values. hsync goes low for 96 cycles starting at sx=656. vsync goes low on lines 490-491. The frame period is 800x525 cycles.
- Small timing (H_ACTIVE=8, H_FP=H_SYNC=H_BP=2, V_ACTIVE=4, V_FP=V_SYNC=V_BP=1, SYNC_POL=1): feed a counting pattern with sof on the first word -> locked is set at frame 0 pixel (0,0), de pixels show 0..31 in order, hsync is high at sx 10-11, and err_cnt stays 0.
- Junk before sof: push 5 words with sof=0 and then a frame -> the junk words are discarded, the first displayed pixel is the sof word at (0,0), and err_cnt stays 0.
- Underflow: stall in_valid mid-line at pixel 20 -> that pixel shows 0, err_cnt becomes 1, and locked drops. The block relocks at the next (0,0) after the stream resumes with sof.
- Early sof at pixel 5 of a line -> that pixel shows 0, err_cnt increments, and the sof word is displayed at the next frame's (0,0).
- Full FIFO: hold in_valid high before locking -> in_ready goes low after FIFO_DEPTH words. No word is lost or duplicated once display starts. An assertion of resync empties the FIFO and restarts the output at (0,0).
